// File: rtl/pe_accum_ctrl.sv
// pe_accum_ctrl: sequencer for the PE accumulation datapath.
// This module owns the accumulator register. The register drives the PE
// adder's previous_sum input and captures the adder's PE_sum result on every
// accepted input batch. After a programmed number of steps, the final sum is
// presented on a valid/ready output port. A one-cycle done pulse follows the
// output handshake.
//
// Optional build macro: PE_ACC_BIAS_EN
//   defined   : an accepted start loads the accumulator from the bias port.
//   undefined : an accepted start clears the accumulator, and bias is ignored.
// The port list is identical in both builds.
module pe_accum_ctrl #(
    parameter int ACC_W = 20,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [ACC_W-1:0] bias,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] pe_prev_sum,
    input  logic [ACC_W-1:0] pe_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             done
);

    // Control states. These are kept as plain constants so the encoding stays
    // visible in waveforms and in older tool flows.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic             done_q,  done_d;

    // Handshake and decode helpers.
    logic             in_fire;
    logic             out_fire;
    logic             start_ok;
    logic             last_step;
    logic [ACC_W-1:0] acc_init;

`ifdef PE_ACC_BIAS_EN
    // The bias seeds the accumulator. The first adder step therefore sees it
    // on previous_sum.
    assign acc_init = bias;
`else
    // Without the bias feature, every job starts from zero. The bias port is
    // still present but is only folded into a sink signal here.
    logic bias_unused;
    assign bias_unused = ^bias;
    assign acc_init    = '0;
`endif

    // A start is honoured only in IDLE, and only once the done pulse of the
    // previous job has already been seen. A start coincident with the done
    // cycle is dropped.
    assign start_ok = (state_q == ST_IDLE) && start && !done_q;

    assign in_fire  = (state_q == ST_ACCUM) && in_valid;
    assign out_fire = (state_q == ST_OUT) && out_ready;

    // The counter holds the number of completed steps. The batch accepted
    // while cnt == len-1 is therefore the final one. When len is at its
    // maximum, the counter tops out at len and never wraps.
    assign last_step = (cnt_q == (len_q - LEN_ONE));

    // Next-state logic for the control FSM and the datapath registers.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    len_d = cfg_len;
                    cnt_d = '0;
                    acc_d = acc_init;
                    // A zero-length job has nothing to add. It goes straight
                    // to the output stage and presents the initial value.
                    if (cfg_len != '0) begin
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
            end

            ST_ACCUM: begin
                // The adder has already combined previous_sum with the batch.
                // This stage only captures the result, so wrap-around is
                // simply the adder's modulo behaviour.
                if (in_fire) begin
                    acc_d = pe_sum;
                    cnt_d = cnt_q + LEN_ONE;
                    if (last_step) begin
                        state_d = ST_OUT;
                    end
                end
            end

            ST_OUT: begin
                if (out_fire) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                // An unreachable encoding recovers to a clean idle state.
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                len_d   = '0;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    // Output decode. Every output except done is a function of the state and
    // the registers, so nothing combinational reaches from input to output.
    always_comb begin
        in_ready    = (state_q == ST_ACCUM);
        out_valid   = (state_q == ST_OUT);
        busy        = (state_q != ST_IDLE);
        pe_prev_sum = acc_q;
        out_data    = acc_q;
        done        = done_q;
    end

endmodule

// File: tb/tb_pe_accum_ctrl.sv
// Testbench for pe_accum_ctrl. It combines fixed vectors, hand-written
// corner sequences, and randomized jobs. The bench contains its own PE adder
// (pe_sum = pe_prev_sum + partial). Expected sums are computed as the initial
// value plus the sum of the partials, modulo 2^20.
module tb_pe_accum_ctrl;

    localparam int ACC_W = 20;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [ACC_W-1:0] bias = '0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] partial = '0;
    logic             in_ready;
    logic [ACC_W-1:0] pe_prev_sum;
    logic [ACC_W-1:0] pe_sum;
    logic             out_valid;
    logic [ACC_W-1:0] out_data;
    logic             busy;
    logic             done;

    pe_accum_ctrl #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_len     (cfg_len),
        .bias        (bias),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pe_prev_sum (pe_prev_sum),
        .pe_sum      (pe_sum),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    // PE adder model.
    assign pe_sum = pe_prev_sum + partial;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs   = 0;
    int checks = 0;

    logic [ACC_W-1:0] model_acc;
    logic [ACC_W-1:0] ps_q[$];

    typedef struct {
        int                   len;
        logic [3:0][ACC_W-1:0] p;
        logic [ACC_W-1:0]     exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [ACC_W-1:0] init_of(input logic [ACC_W-1:0] b);
`ifdef PE_ACC_BIAS_EN
        return b;
`else
        return (b & '0);
`endif
    endfunction

    // Expected result: the initial value plus the sum of the queued partials.
    function automatic logic [ACC_W-1:0] expect_sum(input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        s = init_of(b);
        foreach (ps_q[i]) s = s + ps_q[i];
        return s;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic start_job(input int len, input logic [ACC_W-1:0] b);
        chk("idle_before_start", {31'd0, busy}, 32'd0);
        start   = 1'b1;
        cfg_len = LEN_W'(len);
        bias    = b;
        @(negedge clk);
        start     = 1'b0;
        cfg_len   = '0;
        model_acc = init_of(b);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("acc_init", {12'd0, pe_prev_sum}, {12'd0, model_acc});
        if (len > 0) begin
            chk("first_in_ready", {31'd0, in_ready}, 32'd1);
            chk("no_early_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
            chk("len0_out_valid", {31'd0, out_valid}, 32'd1);
            chk("len0_no_in_ready", {31'd0, in_ready}, 32'd0);
        end
    endtask

    // Feed every queued partial, optionally with random bubbles before each.
    task automatic feed(input int max_bub, input bit final_batch);
        int n;
        n = ps_q.size();
        for (int k = 0; k < n; k++) begin
            int bub;
            bub = $urandom_range(0, max_bub);
            for (int j = 0; j < bub; j++) begin
                in_valid  = 1'b0;
                partial   = $urandom();
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("acc_hold", {12'd0, pe_prev_sum}, {12'd0, model_acc});
                chk("ready_in_bubble", {31'd0, in_ready}, 32'd1);
                chk("no_out_in_bubble", {31'd0, out_valid}, 32'd0);
            end
            chk("in_ready_pre_hs", {31'd0, in_ready}, 32'd1);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            partial   = ps_q[k];
            @(negedge clk);
            in_valid  = 1'b0;
            partial   = '0;
            model_acc = model_acc + ps_q[k];
            chk("acc_update", {12'd0, pe_prev_sum}, {12'd0, model_acc});
            if (final_batch && k == n - 1) begin
                chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
                chk("in_ready_drop", {31'd0, in_ready}, 32'd0);
            end else begin
                chk("still_accum", {31'd0, in_ready}, 32'd1);
                chk("no_out_mid", {31'd0, out_valid}, 32'd0);
            end
        end
    endtask

    // Hold off the output for 'hold' cycles, optionally poking start, then
    // complete the handshake and check the done pulse.
    task automatic collect(input int hold, input bit poke, input logic [ACC_W-1:0] exp);
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("out_data", {12'd0, out_data}, {12'd0, exp});
        for (int j = 0; j < hold; j++) begin
            out_ready = 1'b0;
            start     = poke;
            cfg_len   = 8'd3;
            @(negedge clk);
            start = 1'b0;
            chk("out_valid_stable", {31'd0, out_valid}, 32'd1);
            chk("out_data_stable", {12'd0, out_data}, {12'd0, exp});
            chk("no_done_early", {31'd0, done}, 32'd0);
        end
        out_ready = 1'b1;
        start     = poke;
        cfg_len   = 8'd2;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("idle_after_out", {31'd0, busy}, 32'd0);
        chk("out_valid_clear", {31'd0, out_valid}, 32'd0);
        $display("job: out_data=%h expected=%h hold=%0d poke=%0d", out_data, exp, hold, poke);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("stay_idle", {31'd0, busy}, 32'd0);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        // Fixed vectors: p[0] is the first partial.
        vecs[0] = '{3, {20'h00000, 20'h00010, 20'hFFFFE, 20'h00005}, 20'h00013};
        vecs[1] = '{2, {20'h00000, 20'h00000, 20'h00001, 20'h7FFFF}, 20'h80000};
        vecs[2] = '{1, {20'h00000, 20'h00000, 20'h00000, 20'h00007}, 20'h00007};
        vecs[3] = '{4, {20'h00004, 20'h00003, 20'h00002, 20'h00001}, 20'h0000A};
        vecs[4] = '{4, {20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF}, 20'hFFFFC};

        // Reset asserted mid-cycle.
        #3 rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {12'd0, out_data}, 32'd0);
        chk("rst_prev_sum", {12'd0, pe_prev_sum}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Table vectors with continuous flow and a start-to-done timing check.
        // The bias is driven to show that it is ignored unless enabled.
        for (int v = 0; v < 5; v++) begin
            int c0;
            logic [ACC_W-1:0] e;
            ps_q.delete();
            for (int k = 0; k < vecs[v].len; k++) ps_q.push_back(vecs[v].p[k]);
            e = vecs[v].exp + init_of(20'h00100);
            start_job(vecs[v].len, 20'h00100);
            c0 = cyc;
            feed(0, 1'b1);
            chk("vec_sum", {12'd0, out_data}, {12'd0, e});
            collect(0, 1'b0, e);
            chk("start_to_done", 32'(cyc - c0 - 1), 32'(vecs[v].len + 1));
        end

        // Zero-length job.
        ps_q.delete();
        start_job(0, 20'h00064);
        collect(0, 1'b0, init_of(20'h00064));

        // Backpressure: bubbles, held output, and a start poked during OUT.
        ps_q.delete();
        for (int k = 0; k < 4; k++) ps_q.push_back(20'(k * 3 + 1));
        begin
            logic [ACC_W-1:0] e;
            e = expect_sum(20'h0);
            start_job(4, 20'h0);
            feed(3, 1'b1);
            collect(5, 1'b1, e);
        end

        // Reset after the 2nd of 4 handshakes.
        ps_q.delete();
        ps_q.push_back(20'h00011);
        ps_q.push_back(20'h00022);
        start_job(4, 20'h0);
        feed(0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_acc", {12'd0, pe_prev_sum}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
            chk("abort_no_out", {31'd0, out_valid}, 32'd0);
        end
        ps_q.delete();
        ps_q.push_back(20'h00007);
        start_job(1, 20'h0);
        feed(0, 1'b1);
        collect(0, 1'b0, 20'h00007);

        // Maximum length: 255 steps must finish without counter wrap.
        ps_q.delete();
        for (int k = 0; k < 255; k++) ps_q.push_back(20'($urandom()));
        begin
            logic [ACC_W-1:0] e;
            e = expect_sum(20'h0);
            start_job(255, 20'h0);
            feed(0, 1'b1);
            collect(0, 1'b0, e);
        end

        // Randomized jobs.
        for (int r = 0; r < 20; r++) begin
            int len;
            logic [ACC_W-1:0] b;
            logic [ACC_W-1:0] e;
            len = $urandom_range(0, 6);
            b   = 20'($urandom());
            ps_q.delete();
            for (int k = 0; k < len; k++) ps_q.push_back(20'($urandom()));
            e = expect_sum(b);
            start_job(len, b);
            if (len > 0) feed(2, 1'b1);
            collect($urandom_range(0, 3), 1'($urandom_range(0, 1)), e);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
